// File: rtl/player_manager.sv
// player_manager: turns joystick moves and presses into a player column, a
// player colour and a single bullet in flight. It also decodes the player
// display row.
module player_manager #(
  parameter int unsigned START_COL        = 3,
  parameter int unsigned BULLET_START_ROW = 6,
  parameter int unsigned TOP_ROW          = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        tick,
  input  logic [3:0]  jstk_pos,
  input  logic        jstk_press,
  input  logic        hit,
  output logic [39:0] player_row,
  output logic [2:0]  player_col,
  output logic [1:0]  player_color,
  output logic        bullet_valid,
  output logic [2:0]  bullet_x,
  output logic [2:0]  bullet_y,
  output logic [4:0]  bullet_code,
  output logic        shot_fire
);

  localparam int unsigned COL_W     = 3;
  localparam int unsigned ROW_W     = 3;
  localparam int unsigned CLR_W     = 2;
  localparam int unsigned IMG_W     = 5;
  localparam int unsigned NUM_CELLS = 8;
  localparam int unsigned NUM_CLR   = 3;

  localparam logic [COL_W-1:0] MAX_COL     = COL_W'(NUM_CELLS - 1);
  localparam logic [CLR_W-1:0] MAX_CLR     = CLR_W'(NUM_CLR - 1);
  localparam logic [IMG_W-1:0] BULLET_BASE = IMG_W'(13);
  localparam logic [IMG_W-1:0] PLAYER_BASE = IMG_W'(10);
  localparam logic [IMG_W-1:0] DARK_IMG    = IMG_W'(31);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_FLIGHT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic up_prev, down_prev, left_prev, right_prev, press_prev;
  logic up_edge, down_edge, left_edge, right_edge, press_edge;

  logic [COL_W-1:0] col_nxt;
  logic [CLR_W-1:0] color_nxt;
  logic [COL_W-1:0] bx_nxt;
  logic [ROW_W-1:0] by_nxt;
  logic [IMG_W-1:0] code_nxt;
  logic             fire_nxt;

  // Rising-edge qualification; history is kept even while disabled.
  always_comb begin
    up_edge    = en & jstk_pos[3] & ~up_prev;
    down_edge  = en & jstk_pos[2] & ~down_prev;
    left_edge  = en & jstk_pos[1] & ~left_prev;
    right_edge = en & jstk_pos[0] & ~right_prev;
    press_edge = en & jstk_press   & ~press_prev;
  end

  // Edge-detect history; resets high so held buttons do not act after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_prev    <= 1'b1;
      down_prev  <= 1'b1;
      left_prev  <= 1'b1;
      right_prev <= 1'b1;
      press_prev <= 1'b1;
    end else begin
      up_prev    <= jstk_pos[3];
      down_prev  <= jstk_pos[2];
      left_prev  <= jstk_pos[1];
      right_prev <= jstk_pos[0];
      press_prev <= jstk_press;
    end
  end

  // Next-state for movement, colour and the bullet life cycle.
  always_comb begin
    state_nxt = state;
    col_nxt   = player_col;
    color_nxt = player_color;
    bx_nxt    = bullet_x;
    by_nxt    = bullet_y;
    code_nxt  = bullet_code;
    fire_nxt  = 1'b0;

    // Opposing edges in the same cycle cancel.
    if (left_edge && !right_edge && player_col != '0) begin
      col_nxt = player_col - COL_W'(1);
    end else if (right_edge && !left_edge && player_col != MAX_COL) begin
      col_nxt = player_col + COL_W'(1);
    end

    if (up_edge && !down_edge) begin
      color_nxt = (player_color == MAX_CLR) ? '0 : player_color + CLR_W'(1);
    end else if (down_edge && !up_edge) begin
      color_nxt = (player_color == '0) ? MAX_CLR : player_color - CLR_W'(1);
    end

    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          // Launch uses column and colour as they were before this cycle.
          if (press_edge) begin
            state_nxt = S_FLIGHT;
            bx_nxt    = player_col;
            by_nxt    = ROW_W'(BULLET_START_ROW);
            code_nxt  = BULLET_BASE + IMG_W'(player_color);
            fire_nxt  = 1'b1;
          end
        end
        S_FLIGHT: begin
          if (hit) begin
            state_nxt = S_IDLE;
          end else if (tick) begin
            if (bullet_y > ROW_W'(TOP_ROW)) begin
              by_nxt = bullet_y - ROW_W'(1);
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      player_col   <= COL_W'(START_COL);
      player_color <= '0;
      bullet_valid <= 1'b0;
      bullet_x     <= '0;
      bullet_y     <= '0;
      bullet_code  <= BULLET_BASE;
      shot_fire    <= 1'b0;
    end else begin
      state        <= state_nxt;
      player_col   <= col_nxt;
      player_color <= color_nxt;
      bullet_valid <= (state_nxt == S_FLIGHT);
      bullet_x     <= bx_nxt;
      bullet_y     <= by_nxt;
      bullet_code  <= code_nxt;
      shot_fire    <= fire_nxt;
    end
  end

  // Player row decode: player image at its column, dark elsewhere.
  always_comb begin
    player_row = '0;
    for (int i = 0; i < int'(NUM_CELLS); i++) begin
      player_row[(int'(NUM_CELLS) - 1 - i) * int'(IMG_W) +: IMG_W] =
        (player_col == COL_W'(i)) ? (PLAYER_BASE + IMG_W'(player_color)) : DARK_IMG;
    end
  end

endmodule
